mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting for mem_ack before abort.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have start  input  1  one-cycle request from core control; sampled only in IDLE.
REQ-005 SHALL have MemRW  input  1  0 = load, 1 = store.
REQ-006 SHALL have DataWSel  input  2  store width: 00 word, 01 byte, 11 half; 10 treated as word.
REQ-007 SHALL have DataRSel  input  3  load mode: 000 word, 001 byte, 010 half, 011 byte unsigned, 100 half unsigned; 101-111 treated as word.
REQ-008 SHALL have addr  input  32  byte address of access.
REQ-009 SHALL have wdata  input  32  store data, right-justified.
REQ-010 SHALL have busy  output  1  high from the cycle after accepted start until done.
REQ-011 SHALL have done  output  1  one-cycle completion pulse.
REQ-012 SHALL have rdata  output  32  extended load result.
REQ-013 SHALL have err  output  2  00 ok, 01 misaligned, 10 timeout; valid with done.
REQ-014 SHALL have mem_req, mem_we  output  1 each  bus request and write enable.
REQ-015 SHALL have mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-016 SHALL have mem_be  output  4  byte enables; mem_wdata  output  32  lane-placed store data.
REQ-017 SHALL have mem_ack  input  1 and mem_rdata  input  32  bus response.

Function
REQ-018 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE; start in IDLE latches MemRW, DataWSel, DataRSel, addr, wdata.
REQ-019 SHALL detect misalignment at start: half with addr[0]=1, word with addr[1:0]!=00; then go IDLE -> DONE with err=01, no bus access.
REQ-020 SHALL hold mem_req, mem_we, mem_addr, mem_be, mem_wdata registered and stable throughout BUS until mem_ack.
REQ-021 SHALL latency: start in cycle N -> mem_req high in N+1; mem_ack sampled in cycle M -> mem_req low and done high in M+1.
REQ-022 SHALL for store byte drive mem_wdata = wdata[7:0] replicated x4, mem_be = 0001 << addr[1:0]; half: wdata[15:0] x2, mem_be = addr[1] ? 1100 : 0011; word: wdata, 1111.
REQ-023 SHALL for loads drive mem_be = 1111, mem_we = 0, select lane by addr[1:0] (half by addr[1]), sign-extend for 001/010, zero-extend for 011/100.
REQ-024 SHALL register rdata on mem_ack of a load and hold it until the next load completes; stores and errors leave rdata unchanged.
REQ-025 SHALL count BUS cycles; mem_ack absent after TIMEOUT_CYCLES cycles -> drop mem_req, DONE with err=10.
REQ-026 SHALL ignore start while busy or in DONE; no queuing.
REQ-027 SHALL give mem_ack precedence over timeout when both occur in the same cycle (err=00).
REQ-028 SHALL ignore mem_ack outside BUS.
REQ-029 SHALL keep busy=0 and done=0 in IDLE; done is high exactly one cycle, in DONE.

Reset
REQ-030 SHALL on rst=1, immediately and regardless of clk: state IDLE, busy/done/mem_req/mem_we 0, mem_be 0000, mem_addr/mem_wdata/rdata 0, err 00, timeout counter 0.
REQ-031 SHALL abandon an in-flight bus access on reset with no done pulse.

Structure
REQ-032 SHALL place DataWSel/DataRSel encodings, err codes and FSM state encoding in shared package mem_pkg, used also by sub_decoder consumers.
REQ-033 SHALL contain one combinational sub-module load_extend (lane select plus sign/zero extension).

Verification
REQ-034 SHALL test store byte addr=0x1002 wdata=0x000000AB, ack after 3 cycles -> mem_addr=0x1000, mem_be=0100, mem_wdata=0xABABABAB, done 1 cycle after ack, err=00.
REQ-035 SHALL test load byte signed addr=0x2003, mem_rdata=0x80FF1234 -> rdata=0xFFFFFF80; same with DataRSel=011 -> 0x00000080.
REQ-036 SHALL test load half signed addr=0x2001 -> no mem_req, done next cycle, err=01, rdata unchanged.
REQ-037 SHALL test TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then low, done with err=10.
REQ-038 SHALL test start pulse during BUS -> ignored; rst mid-BUS -> mem_req low immediately, no done, next start processed normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store memory access unit.
// Width/mode codes, error codes, FSM states and lane placement helpers.
package mem_pkg;

   typedef enum logic [1:0] {
      WSEL_WORD     = 2'b00,
      WSEL_BYTE     = 2'b01,
      WSEL_WORD_ALT = 2'b10,
      WSEL_HALF     = 2'b11
   } wsel_e;

   typedef enum logic [2:0] {
      RSEL_WORD  = 3'b000,
      RSEL_BYTE  = 3'b001,
      RSEL_HALF  = 3'b010,
      RSEL_BYTEU = 3'b011,
      RSEL_HALFU = 3'b100
   } rsel_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } size_e;

   function automatic size_e access_size(
      input logic       we,
      input logic [1:0] wsel,
      input logic [2:0] rsel
   );
      size_e s;
      s = SZ_WORD;
      if (we) begin
         if (wsel == WSEL_BYTE) s = SZ_BYTE;
         else if (wsel == WSEL_HALF) s = SZ_HALF;
      end else begin
         case (rsel)
            RSEL_BYTE, RSEL_BYTEU: s = SZ_BYTE;
            RSEL_HALF, RSEL_HALFU: s = SZ_HALF;
            default:               s = SZ_WORD;
         endcase
      end
      return s;
   endfunction

   function automatic logic misaligned(
      input size_e      sz,
      input logic [1:0] off
   );
      case (sz)
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(
      input size_e      sz,
      input logic [1:0] off
   );
      case (sz)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(
      input size_e       sz,
      input logic [31:0] wd
   );
      case (sz)
         SZ_BYTE: return {4{wd[7:0]}};
         SZ_HALF: return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a bus word and extends it
// according to the load mode.
module load_extend
   import mem_pkg::*;
(
   input  logic [2:0]  rsel,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (rsel)
         RSEL_BYTE:  data = {{24{b[7]}}, b};
         RSEL_HALF:  data = {{16{h[15]}}, h};
         RSEL_BYTEU: data = {24'b0, b};
         RSEL_HALFU: data = {16'b0, h};
         default:    data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store bus master with alignment check,
// lane placement, load extension and ack timeout.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        MemRW,
   input  logic [1:0]  DataWSel,
   input  logic [2:0]  DataRSel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e         state_q, state_d;
   logic           we_q;
   logic [2:0]     rsel_q;
   logic [1:0]     lane_q;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    ext;
   size_e          sz;
   logic           misal;
   logic           accept;
   logic           ack_hit;
   logic           to_hit;

   load_extend u_ext (
      .rsel (rsel_q),
      .lane (lane_q),
      .word (mem_rdata),
      .data (ext)
   );

   assign sz    = access_size(MemRW, DataWSel, DataRSel);
   assign misal = misaligned(sz, addr[1:0]);
   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ack is checked before the timeout so a last-cycle ack still succeeds
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      ack_hit = 1'b0;
      to_hit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = misal ? ST_DONE : ST_BUS;
            end
         end
         ST_BUS: begin
            if (mem_ack) begin
               ack_hit = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q == LAST) begin
               to_hit  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q      <= 1'b0;
         rsel_q    <= 3'b000;
         lane_q    <= 2'b00;
         cnt_q     <= '0;
         rdata     <= 32'h0;
         err       <= ERR_OK;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
      end else if (accept) begin
         we_q   <= MemRW;
         rsel_q <= DataRSel;
         lane_q <= addr[1:0];
         cnt_q  <= '0;
         if (misal) begin
            err <= ERR_MISALIGN;
         end else begin
            err       <= ERR_OK;
            mem_req   <= 1'b1;
            mem_we    <= MemRW;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= MemRW ? store_be(sz, addr[1:0]) : 4'b1111;
            mem_wdata <= MemRW ? store_data(sz, wdata) : 32'h0;
         end
      end else if (ack_hit) begin
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         if (!we_q) rdata <= ext;
      end else if (to_hit) begin
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         err     <= ERR_TIMEOUT;
      end else if (state_q == ST_BUS) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level
// reference model and literal spot checks.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        MemRW = 1'b0;
   logic [1:0]  DataWSel = 2'b00;
   logic [2:0]  DataRSel = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done;
   logic [31:0] rdata;
   logic [1:0]  err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int nvec = 0;
   int nbad = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .MemRW     (MemRW),
      .DataWSel  (DataWSel),
      .DataRSel  (DataRSel),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   int          m_phase;   // 0 idle, 1 waiting on bus, 2 completing
   int          m_waited;
   int          m_n, m_off;
   bit          m_we, m_sgn;
   logic        e_req, e_we;
   logic [31:0] e_addr, e_wdata, e_rdata;
   logic [3:0]  e_be;
   logic [1:0]  e_err;

   function automatic int nbytes(logic we, logic [1:0] ws, logic [2:0] rs);
      if (we) return (ws == 2'b01) ? 1 : (ws == 2'b11) ? 2 : 4;
      if (rs == 3'b001 || rs == 3'b011) return 1;
      if (rs == 3'b010 || rs == 3'b100) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] repl(logic [31:0] wd, int n);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] load_val(logic [31:0] rd, int off,
                                             int n, bit sgn);
      logic [31:0] v, mask;
      v    = rd >> (8 * off);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v    = v & mask;
      if (sgn && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_waited = 0;
         e_req = 0; e_we = 0; e_addr = 0; e_be = 0;
         e_wdata = 0; e_rdata = 0; e_err = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
               m_we  = MemRW;
               m_n   = nbytes(MemRW, DataWSel, DataRSel);
               m_off = int'(addr % 4);
               m_sgn = !MemRW && (DataRSel == 3'b001 || DataRSel == 3'b010);
               if (m_off % m_n != 0) begin
                  m_phase = 2; e_err = 2'd1;
               end else begin
                  m_phase = 1; m_waited = 0; e_err = 2'd0;
                  e_req = 1; e_we = MemRW;
                  e_addr = addr & ~32'd3;
                  e_be = MemRW ? 4'(((1 << m_n) - 1) << m_off) : 4'hF;
                  e_wdata = MemRW ? repl(wdata, m_n) : 32'h0;
               end
            end
            1: if (mem_ack) begin
               m_phase = 2; e_req = 0; e_we = 0;
               if (!m_we) e_rdata = load_val(mem_rdata, m_off, m_n, m_sgn);
            end else begin
               m_waited++;
               if (m_waited == TO) begin
                  m_phase = 2; e_req = 0; e_we = 0; e_err = 2'd2;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'(m_phase == 2));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("rdata", rdata, e_rdata);
      if (e_req) begin
         check("mem_addr", mem_addr, e_addr);
         check("mem_be", 32'(mem_be), 32'(e_be));
      end
      if (e_req && e_we) check("mem_wdata", mem_wdata, e_wdata);
      if (m_phase == 2) check("err", 32'(err), 32'(e_err));
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic we, input logic [1:0] ws,
                        input logic [2:0] rs, input logic [31:0] a,
                        input logic [31:0] wd);
      @(posedge clk); #2;
      start = 1; MemRW = we; DataWSel = ws; DataRSel = rs;
      addr = a; wdata = wd;
      @(posedge clk); #2;
      start = 0;
   endtask

   task automatic ack_after(input int n, input logic [31:0] rd);
      repeat (n - 1) begin @(posedge clk); #2; end
      mem_ack = 1; mem_rdata = rd;
      @(posedge clk); #2;
      mem_ack = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_be", 32'(mem_be), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk); #2; rst = 0;

      issue(1, 2'b01, 3'b000, 32'h0000_1002, 32'h0000_00AB);
      @(negedge clk);
      check("sb_addr", mem_addr, 32'h0000_1000);
      check("sb_be", 32'(mem_be), 32'h4);
      check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      ack_after(3, 32'h0);
      @(negedge clk);
      check("sb_done", 32'(done), 32'd1);
      check("sb_err", 32'(err), 32'd0);

      issue(0, 2'b00, 3'b001, 32'h0000_2003, 32'h0);
      ack_after(2, 32'h80FF_1234);
      @(negedge clk);
      check("lb_rdata", rdata, 32'hFFFF_FF80);

      issue(0, 2'b00, 3'b011, 32'h0000_2003, 32'h0);
      ack_after(1, 32'h80FF_1234);
      @(negedge clk);
      check("lbu_rdata", rdata, 32'h0000_0080);

      issue(0, 2'b00, 3'b010, 32'h0000_2001, 32'h0);
      @(negedge clk);
      check("mis_done", 32'(done), 32'd1);
      check("mis_err", 32'(err), 32'd1);
      check("mis_req", 32'(mem_req), 32'd0);
      check("mis_rdata", rdata, 32'h0000_0080);

      issue(1, 2'b11, 3'b000, 32'h0000_3002, 32'h1234_CDEF);
      @(negedge clk);
      check("sh_be", 32'(mem_be), 32'hC);
      check("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
      ack_after(2, 32'h0);

      issue(1, 2'b00, 3'b000, 32'h0000_4000, 32'hDEAD_BEEF);
      ack_after(1, 32'h0);
      issue(1, 2'b10, 3'b000, 32'h0000_7000, 32'h0102_0304);
      @(negedge clk);
      check("sw10_be", 32'(mem_be), 32'hF);
      ack_after(1, 32'h0);
      issue(1, 2'b10, 3'b000, 32'h0000_7001, 32'h0);

      issue(0, 2'b00, 3'b100, 32'h0000_5002, 32'h0);
      ack_after(2, 32'h8001_7FFF);
      @(negedge clk);
      check("lhu_rdata", rdata, 32'h0000_8001);
      issue(0, 2'b00, 3'b010, 32'h0000_5000, 32'h0);
      ack_after(1, 32'h8001_7FFF);
      issue(0, 2'b00, 3'b010, 32'h0000_5002, 32'h0);
      ack_after(1, 32'h8001_7FFF);
      @(negedge clk);
      check("lh_rdata", rdata, 32'hFFFF_8001);
      issue(0, 2'b00, 3'b111, 32'h0000_5004, 32'h0);
      ack_after(1, 32'h1357_9BDF);

      issue(0, 2'b00, 3'b000, 32'h0000_6000, 32'h0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) n++;
         else break;
      end
      check("to_req_cycles", 32'(n), 32'd4);
      check("to_done", 32'(done), 32'd1);
      check("to_err", 32'(err), 32'd2);
      check("to_rdata", rdata, 32'h1357_9BDF);

      issue(0, 2'b00, 3'b000, 32'h0000_6004, 32'h0);
      ack_after(TO, 32'h2468_ACE0);
      @(negedge clk);
      check("race_err", 32'(err), 32'd0);
      check("race_rdata", rdata, 32'h2468_ACE0);

      issue(0, 2'b00, 3'b000, 32'h0000_A000, 32'h0);
      @(posedge clk); #2;
      start = 1; MemRW = 1; addr = 32'h0000_B000; wdata = 32'hFFFF_FFFF;
      @(posedge clk); #2;
      start = 0;
      mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
      @(posedge clk); #2;
      mem_ack = 0;
      @(negedge clk);
      check("ign_rdata", rdata, 32'h0BAD_F00D);
      @(negedge clk);
      check("ign_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("ign_noq", 32'(busy), 32'd0);

      mem_ack = 1; mem_rdata = 32'h5555_5555;
      repeat (3) @(negedge clk);
      mem_ack = 0;
      check("stray_ack", rdata, 32'h0BAD_F00D);

      issue(0, 2'b00, 3'b000, 32'h0000_8000, 32'h0);
      @(posedge clk); #2;
      rst = 1;
      #1;
      check("rst_mid_req", 32'(mem_req), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      @(posedge clk); #2;
      rst = 0;
      issue(1, 2'b00, 3'b000, 32'h0000_9000, 32'hCAFE_F00D);
      @(negedge clk);
      check("post_rst_wdata", mem_wdata, 32'hCAFE_F00D);
      ack_after(2, 32'h0);
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd1);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
